// File: rtl/slave_rx_pkg.sv
// Shared types and sizing helpers for the multi-lane serial slave receiver.
package slave_rx_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_SHIFT,
      RX_PARITY
   } rx_state_e;

   function automatic int unsigned beats(input int unsigned data_width, input int unsigned lanes);
      return data_width / lanes;
   endfunction

   // A single-beat word still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slave_rx_fifo.sv
// Synchronous FIFO buffering assembled words; full-FIFO push is accepted only alongside a pop.
module slave_rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign level_o = level_q;
   assign data_o  = empty_o ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/multilane_slave_rx.sv
// Multi-lane serial slave receiver: CS-gated beat assembly, FIFO buffering, valid/ready output.
// Define SLAVE_RX_PARITY_EN to add a trailing even-parity beat per word and tag words with rx_perr.
module multilane_slave_rx
   import slave_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LANES      = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MSB_FIRST  = 1
) (
   input  logic                          sclk,
   input  logic                          rstn,
   input  logic                          CS,
   input  logic [LANES-1:0]              InLine,
   output logic [DATA_WIDTH-1:0]         rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          rx_perr,
   output logic                          frame_abort,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned BEATS = beats(DATA_WIDTH, LANES);
   localparam int unsigned CW    = cnt_width(BEATS);
`ifdef SLAVE_RX_PARITY_EN
   localparam int unsigned FW = DATA_WIDTH + 1;
`else
   localparam int unsigned FW = DATA_WIDTH;
`endif

   rx_state_e             state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
   logic                  abort_q, abort_d;
   logic                  ovf_q, ovf_d;
   logic                  push, pop, full, empty;
   logic [FW-1:0]         push_data, head;

   // Every bit of the shift register is replaced after BEATS beats, so no clear between words.
   always_comb begin
      if (MSB_FIRST != 0) begin
         shifted = (shift_q << LANES) | DATA_WIDTH'(InLine);
      end else begin
         shifted = (shift_q >> LANES) | (DATA_WIDTH'(InLine) << (DATA_WIDTH - LANES));
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      push    = 1'b0;
      abort_d = 1'b0;
`ifdef SLAVE_RX_PARITY_EN
      push_data = {^shift_q ^ InLine[0], shift_q};
`else
      push_data = shifted;
`endif
      if (CS) begin
         abort_d = (state_q == RX_PARITY) || (cnt_q != '0);
         state_d = RX_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            RX_IDLE, RX_SHIFT: begin
               shift_d = shifted;
               if (cnt_q == CW'(BEATS - 1)) begin
                  cnt_d = '0;
`ifdef SLAVE_RX_PARITY_EN
                  state_d = RX_PARITY;
`else
                  state_d = RX_SHIFT;
                  push    = 1'b1;
`endif
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  state_d = RX_SHIFT;
               end
            end
`ifdef SLAVE_RX_PARITY_EN
            RX_PARITY: begin
               push    = 1'b1;
               state_d = RX_SHIFT;
            end
`endif
            default: state_d = RX_IDLE;
         endcase
      end
   end

   assign pop   = rx_valid & rx_ready;
   assign ovf_d = push & full & ~pop;

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         abort_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         abort_q <= abort_d;
         ovf_q   <= ovf_d;
      end
   end

   slave_rx_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (sclk),
      .rst_ni  (rstn),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level)
   );

   assign rx_valid    = ~empty;
   assign frame_abort = abort_q;
   assign overflow    = ovf_q;
`ifdef SLAVE_RX_PARITY_EN
   assign rx_data = head[DATA_WIDTH-1:0];
   assign rx_perr = head[DATA_WIDTH];
`else
   assign rx_data = head;
   assign rx_perr = 1'b0;
`endif

endmodule

// File: tb/tb_multilane_slave_rx.sv
// Scoreboard bench: three receiver configurations (MSB-first, LSB-first, 4-lane 16-bit).
module tb_multilane_slave_rx;

   logic        sclk = 1'b0;
   logic        rstn = 1'b0;
   logic        rdy  = 1'b0;
   logic        cs0  = 1'b1;
   logic        cs2  = 1'b1;
   logic [1:0]  ln0  = '0;
   logic [3:0]  ln2  = '0;
   logic [7:0]  data0, data1;
   logic [15:0] data2;
   logic        v0, v1, v2, perr0, perr1, perr2, fa0, fa1, fa2, ov0, ov1, ov2;
   logic [2:0]  lvl0, lvl1, lvl2;

   int checks = 0;
   int failures = 0;
   int ab0 = 0, ab1 = 0, ab2 = 0, ovc0 = 0, ovc1 = 0, ovc2 = 0;
   int abs0;
   logic [31:0] q0[$], q1[$], q2[$];

   always #5 sclk = ~sclk;

   multilane_slave_rx #(.DATA_WIDTH(8), .LANES(2), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut0 (
      .sclk(sclk), .rstn(rstn), .CS(cs0), .InLine(ln0), .rx_data(data0), .rx_valid(v0),
      .rx_ready(rdy), .rx_perr(perr0), .frame_abort(fa0), .overflow(ov0), .fifo_level(lvl0)
   );

   multilane_slave_rx #(.DATA_WIDTH(8), .LANES(2), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut1 (
      .sclk(sclk), .rstn(rstn), .CS(cs0), .InLine(ln0), .rx_data(data1), .rx_valid(v1),
      .rx_ready(rdy), .rx_perr(perr1), .frame_abort(fa1), .overflow(ov1), .fifo_level(lvl1)
   );

   multilane_slave_rx #(.DATA_WIDTH(16), .LANES(4), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut2 (
      .sclk(sclk), .rstn(rstn), .CS(cs2), .InLine(ln2), .rx_data(data2), .rx_valid(v2),
      .rx_ready(rdy), .rx_perr(perr2), .frame_abort(fa2), .overflow(ov2), .fifo_level(lvl2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Head word must match the scoreboard whenever valid; it is consumed only on ready.
   always @(negedge sclk) begin
      if (rstn && v0) begin
         if (q0.size() == 0) chk("d0_unexpected_word", 32'(data0), 32'hffff_ffff);
         else begin
            chk("d0_word", 32'({perr0, data0}), q0[0]);
            if (rdy) void'(q0.pop_front());
         end
      end
      if (rstn && v1) begin
         if (q1.size() == 0) chk("d1_unexpected_word", 32'(data1), 32'hffff_ffff);
         else begin
            chk("d1_word", 32'({perr1, data1}), q1[0]);
            if (rdy) void'(q1.pop_front());
         end
      end
      if (rstn && v2) begin
         if (q2.size() == 0) chk("d2_unexpected_word", 32'(data2), 32'hffff_ffff);
         else begin
            chk("d2_word", 32'({perr2, data2}), q2[0]);
            if (rdy) void'(q2.pop_front());
         end
      end
      if (fa0) ab0++;
      if (fa1) ab1++;
      if (fa2) ab2++;
      if (ov0) ovc0++;
      if (ov1) ovc1++;
      if (ov2) ovc2++;
   end

   // Drives one 8-bit word to dut0/dut1; beat i carries w[7-2i -: 2].
   task automatic send8(input logic [7:0] w, input logic pbit, input bit expect_push);
      logic [7:0] lw;
      logic       perr;
      for (int i = 0; i < 4; i++) begin
         @(posedge sclk); #1;
         cs0 = 1'b0;
         ln0 = w[7-2*i -: 2];
         lw[2*i +: 2] = w[7-2*i -: 2];
      end
`ifdef SLAVE_RX_PARITY_EN
      @(posedge sclk); #1;
      ln0  = {1'b0, pbit};
      perr = ^w ^ pbit;
`else
      perr = 1'b0;
`endif
      if (expect_push) begin
         q0.push_back({23'b0, perr, w});
         q1.push_back({23'b0, perr, lw});
      end
   endtask

   task automatic send16(input logic [15:0] w, input logic pbit);
      logic perr;
      for (int i = 0; i < 4; i++) begin
         @(posedge sclk); #1;
         cs2 = 1'b0;
         ln2 = w[15-4*i -: 4];
      end
`ifdef SLAVE_RX_PARITY_EN
      @(posedge sclk); #1;
      ln2  = {3'b0, pbit};
      perr = ^w ^ pbit;
`else
      perr = 1'b0;
`endif
      q2.push_back({15'b0, perr, w});
   endtask

   task automatic end_frame();
      @(posedge sclk); #1;
      cs0 = 1'b1;
      cs2 = 1'b1;
   endtask

   initial begin
      #12;
      chk("rst_valid", 32'({v0, v1, v2}), 32'd0);
      chk("rst_data", 32'(data0), 32'd0);
      chk("rst_level", 32'({lvl0, lvl2}), 32'd0);
      chk("rst_flags", 32'({fa0, ov0, perr0, fa2, ov2, perr2}), 32'd0);
      @(negedge sclk);
      rstn = 1'b1;
      rdy  = 1'b1;

      // Basic word and one-cycle latency.
      send8(8'b1001_1001, 1'b0, 1'b1);
      @(negedge sclk);
      chk("latency_before", 32'(v0), 32'd0);
      @(posedge sclk); #1;
      cs0 = 1'b1;
      @(negedge sclk);
      chk("latency_after_d0", 32'(v0), 32'd1);
      chk("latency_after_d1", 32'(v1), 32'd1);
      repeat (4) @(negedge sclk);
      chk("basic_drained", 32'(q0.size() + q1.size()), 32'd0);

      // Back-to-back random words, CS held low.
      for (int k = 0; k < 4; k++) send8(8'($urandom), 1'($urandom), 1'b1);
      end_frame();
      repeat (4) @(negedge sclk);
      chk("b2b_drained", 32'(q0.size() + q1.size()), 32'd0);

      // Overflow: five words into a 4-deep FIFO with ready low.
      @(posedge sclk); #1;
      rdy = 1'b0;
      for (int k = 0; k < 5; k++) send8(8'(8'h11 * (k + 1)), 1'b0, k < 4);
      end_frame();
      repeat (3) @(negedge sclk);
      chk("ovf_level_d0", 32'(lvl0), 32'd4);
      chk("ovf_level_d1", 32'(lvl1), 32'd4);
      chk("ovf_pulses_d0", 32'(ovc0), 32'd1);
      chk("ovf_pulses_d1", 32'(ovc1), 32'd1);
      @(posedge sclk); #1;
      rdy = 1'b1;
      repeat (8) @(negedge sclk);
      chk("ovf_drained", 32'(q0.size() + q1.size()), 32'd0);
      chk("ovf_level_empty", 32'(lvl0), 32'd0);

      // Abort after 2 of 4 beats, then a clean word.
      @(posedge sclk); #1;
      cs0 = 1'b0; ln0 = 2'b11;
      @(posedge sclk); #1;
      ln0 = 2'b00;
      end_frame();
      repeat (4) @(negedge sclk);
      chk("abort_d0", 32'(ab0), 32'd1);
      chk("abort_d1", 32'(ab1), 32'd1);
      chk("abort_no_push", 32'(lvl0), 32'd0);
      send8(8'h5A, 1'b0, 1'b1);
      end_frame();
      repeat (4) @(negedge sclk);
      chk("after_abort_drained", 32'(q0.size() + q1.size()), 32'd0);
      chk("abort_count_stable", 32'(ab0), 32'd1);

      // 4-lane 16-bit stream: two words in one frame.
      send16(16'hA5C3, 1'b0);
      send16(16'h1234, 1'b1);
      end_frame();
      repeat (5) @(negedge sclk);
      chk("wide_drained", 32'(q2.size()), 32'd0);
      chk("wide_no_abort", 32'(ab2), 32'd0);

`ifdef SLAVE_RX_PARITY_EN
      send8(8'hA5, 1'b0, 1'b1);
      send8(8'hA5, 1'b1, 1'b1);
      end_frame();
      repeat (5) @(negedge sclk);
      chk("parity_drained", 32'(q0.size()), 32'd0);
`endif

      // Reset mid-word with a word pending in the FIFO.
      @(posedge sclk); #1;
      rdy = 1'b0;
      send8(8'h3C, 1'b0, 1'b1);
      @(posedge sclk); #1;
      ln0 = 2'b01;
      @(posedge sclk); #1;
      ln0 = 2'b10;
      #3 rstn = 1'b0;
      #1;
      chk("midrst_valid", 32'({v0, v1}), 32'd0);
      chk("midrst_data", 32'({data0, data1}), 32'd0);
      chk("midrst_level", 32'({lvl0, lvl1}), 32'd0);
      chk("midrst_flags", 32'({fa0, ov0, perr0}), 32'd0);
      cs0 = 1'b1;
      q0.delete();
      q1.delete();
      abs0 = ab0;
      @(negedge sclk);
      rstn = 1'b1;
      rdy  = 1'b1;
      repeat (3) @(negedge sclk);
      chk("postrst_no_abort", 32'(ab0), 32'(abs0));
      chk("postrst_valid", 32'(v0), 32'd0);
      send8(8'hC3, 1'b1, 1'b1);
      end_frame();
      repeat (5) @(negedge sclk);
      chk("postrst_drained", 32'(q0.size() + q1.size()), 32'd0);
      chk("final_ovf_d0", 32'(ovc0), 32'd1);
      chk("final_ovf_d2", 32'(ovc2), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
